// File: rtl/rsa_precompute.sv
// rsa_precompute: bit-serial N_INV = -N^-1 mod 2^WIDTH and R2_MOD_N = 2^(2*WIDTH) mod N; RSA_PRECOMPUTE_SELFCHECK_EN adds a CHECK cycle
module rsa_precompute #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] N_INV,
  output logic [WIDTH-1:0] R2_MOD_N
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(2 * WIDTH - 1);
  typedef enum logic [1:0] {IDLE, INV, R2, CHECK} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] n_q, x, p, ninv, res;
  logic [WIDTH:0] r, t, r_d;
  logic [IW-1:0] i;
  logic [CW-1:0] cnt;
  logic inv_last, r2_last, fin, bad;
  // Low-half product for the inverse bit test, doubling step for R^2, and final-result selection
  always_comb begin
    p = n_q * x;
    t = {r[WIDTH-1:0], 1'b0};
    r_d = (t >= {1'b0, n_q}) ? t - {1'b0, n_q} : t;
    ninv = ~x + WIDTH'(1);
    inv_last = (state == INV) && (i == I_LAST);
    r2_last = (state == R2) && (cnt == C_LAST);
`ifdef RSA_PRECOMPUTE_SELFCHECK_EN
    fin = (state == CHECK);
    res = r[WIDTH-1:0];
    bad = (n_q * ninv) != '1;
`else
    fin = r2_last;
    res = r_d[WIDTH-1:0];
    bad = 1'b0;
`endif
  end
  // Next-state: IDLE -> INV -> R2 (-> CHECK) -> IDLE; even N never leaves IDLE
  always_comb begin
    state_d = state;
    if (state == IDLE && start && N[0]) state_d = INV;
    if (inv_last) state_d = R2;
`ifdef RSA_PRECOMPUTE_SELFCHECK_EN
    if (r2_last) state_d = CHECK;
    if (state == CHECK) state_d = IDLE;
`else
    if (r2_last) state_d = IDLE;
`endif
  end
  // State register, iteration datapath and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      N_INV <= '0;
      R2_MOD_N <= '0;
      n_q <= '0;
      x <= '0;
      r <= '0;
      i <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      done <= 1'b0;
      if (state == IDLE && start) begin
        done <= ~N[0];
        err <= ~N[0];
        busy <= N[0];
        if (N[0]) begin
          n_q <= N;
          x <= WIDTH'(1);
          i <= IW'(1);
        end
      end
      if (state == INV) begin
        x <= x | ({{(WIDTH-1){1'b0}}, p[i]} << i);
        i <= i + 1'b1;
        if (inv_last) begin
          r <= (n_q == WIDTH'(1)) ? '0 : (WIDTH+1)'(1);
          cnt <= '0;
        end
      end
      if (state == R2) begin
        r <= r_d;
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        N_INV <= ninv;
        R2_MOD_N <= res;
        err <= bad;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule
